regfile_write_bank: RTL and testbench

//  Write side of the 32-entry CPU register file. Accepts one write request per cycle

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_write_bank_decoder5_32.sv | 18 +
 rtl/regfile_write_bank.sv | 104 ++++++++++
 tb/tb_regfile_write_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and types
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd31;

endpackage

// File: rtl/regfile_write_bank_decoder5_32.sv
// rtl/regfile_write_bank_decoder5_32.sv - 5-to-32 one-hot decoder with enable
module decoder5_32
  import regfile_pkg::*;
(
  input  reg_addr_t             in,
  input  logic                  en,
  output logic [NUM_REGS-1:0]   out
);

  // One-hot select of the addressed line; all lines low when disabled
  always_comb begin
    out = '0;
    if (en) begin
      out[in] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_bank.sv
// rtl/regfile_write_bank.sv - staged write port and storage of the 32-entry register file
module regfile_write_bank
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  reg_addr_t                        wr_addr,
  input  logic [WIDTH-1:0]                 wr_data,
  input  logic                             hold,
  output logic                             pend_valid,
  output reg_addr_t                        pend_addr,
  output logic [WIDTH-1:0]                 pend_data,
  output logic [WIDTH-1:0][NUM_REGS-1:0]   regs_out
);

  logic             pend_valid_q, pend_valid_d;
  reg_addr_t        pend_addr_q,  pend_addr_d;
  logic [WIDTH-1:0] pend_data_q,  pend_data_d;

  logic                transfer;
  logic                commit;
  logic                dec_en;
  logic [NUM_REGS-1:0] wr_en;
  logic                dec_unused;

  // The slot frees on the same edge that it commits, so a held slot is the only back-pressure
  assign wr_ready = !pend_valid_q || !hold;
  assign transfer = wr_valid && wr_ready;
  assign commit   = pend_valid_q && !hold;

  assign pend_valid = pend_valid_q;
  assign pend_addr  = pend_addr_q;
  assign pend_data  = pend_data_q;

  // Staging slot next state: a new transfer overwrites, otherwise a commit empties it
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (transfer) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = wr_addr;
      pend_data_d  = wr_data;
    end else if (commit) begin
      pend_valid_d = 1'b0;
    end
  end

  // Staging slot registers; reset discards any staged write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  // Writes to the zero register are staged but never enable a storage row
  assign dec_en = commit && (pend_addr_q != ZERO_REG);

  decoder5_32 u_decoder (
    .in  (pend_addr_q),
    .en  (dec_en),
    .out (wr_en)
  );

  // The zero register has no storage, so its decode line goes nowhere
  assign dec_unused = wr_en[NUM_REGS-1];

  for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_reg
    logic [WIDTH-1:0] rf_q, rf_d;

    // Row load when its one-hot enable fires, otherwise hold
    always_comb begin
      rf_d = wr_en[r] ? pend_data_q : rf_q;
    end

    // Row storage with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rf_q <= '0;
      end else begin
        rf_q <= rf_d;
      end
    end
  end

  // Bit-sliced view for the read-port muxes: regs_out[b][r] is bit b of register r
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_row
      assign regs_out[b][r] = g_reg[r].rf_q[b];
    end
    assign regs_out[b][NUM_REGS-1] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_bank.sv
// tb/tb_regfile_write_bank.sv - self-checking bench for regfile_write_bank
module tb_regfile_write_bank;
  import regfile_pkg::*;

  localparam int W = 64;

  logic                     clk      = 1'b0;
  logic                     reset_n  = 1'b0;
  logic                     wr_valid = 1'b0;
  logic                     hold     = 1'b0;
  logic [4:0]               wr_addr  = '0;
  logic [W-1:0]             wr_data  = '0;
  logic                     wr_ready;
  logic                     pend_valid;
  logic [4:0]               pend_addr;
  logic [W-1:0]             pend_data;
  logic [W-1:0][31:0]       regs_out;

  regfile_write_bank #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .hold       (hold),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_data  (pend_data),
    .regs_out   (regs_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dut_reg(input int r);
    logic [W-1:0] v;
    for (int b = 0; b < W; b++) v[b] = regs_out[b][r];
    return v;
  endfunction

  // Reference: architectural register array plus a single pending write
  logic [W-1:0] m_regs [32];
  bit           m_pv;
  logic [4:0]   m_pa;
  logic [W-1:0] m_pd;
  bit           m_commit, m_accept;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_pv = 1'b0;
    end else begin
      m_commit = m_pv && !hold;
      m_accept = wr_valid && (!m_pv || !hold);
      if (m_commit && m_pa != 5'd31) m_regs[m_pa] = m_pd;
      if (m_accept) begin
        m_pv = 1'b1;
        m_pa = wr_addr;
        m_pd = wr_data;
      end else if (m_commit) begin
        m_pv = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the reference, just after each edge
  always @(posedge clk) begin
    #1;
    if (reset_n && chk_en) begin
      check("wr_ready", W'(wr_ready), W'(!m_pv || !hold));
      check("pend_valid", W'(pend_valid), W'(m_pv));
      if (m_pv) begin
        check("pend_addr", W'(pend_addr), W'(m_pa));
        check("pend_data", pend_data, m_pd);
      end
      for (int r = 0; r < 32; r++) check($sformatf("reg_x%0d", r), dut_reg(r), m_regs[r]);
    end
  end

  task automatic stage(input logic [4:0] a, input logic [W-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  bit acc;

  initial begin
    // Reset state, with a transfer presented that must be dropped
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 64'h1;
    #1;
    check("rst_wr_ready", W'(wr_ready), W'(1));
    check("rst_pend_valid", W'(pend_valid), W'(0));
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    check("rst_drop_x3", dut_reg(3), 64'h0);
    check("rst_drop_pend", W'(pend_valid), W'(0));

    // Basic write
    stage(5'd3, 64'hDEAD_BEEF_0123_4567);
    check("basic_pend_valid", W'(pend_valid), W'(1));
    check("basic_pend_addr", W'(pend_addr), W'(3));
    check("basic_x3_before", dut_reg(3), 64'h0);
    @(negedge clk);
    check("basic_x3", dut_reg(3), 64'hDEAD_BEEF_0123_4567);
    check("basic_pend_clear", W'(pend_valid), W'(0));

    // Back-to-back, same address twice
    wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 64'd5;
    check("b2b_ready0", W'(wr_ready), W'(1));
    @(negedge clk);
    wr_addr = 5'd2; wr_data = 64'd6;
    check("b2b_ready1", W'(wr_ready), W'(1));
    @(negedge clk);
    wr_addr = 5'd1; wr_data = 64'd7;
    check("b2b_ready2", W'(wr_ready), W'(1));
    check("b2b_x1_mid", dut_reg(1), 64'd5);
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    check("b2b_x1", dut_reg(1), 64'd7);
    check("b2b_x2", dut_reg(2), 64'd6);

    // Hold stalls the commit and blocks the next request
    stage(5'd4, 64'hA5);
    hold = 1'b1; wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 64'h5A;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_ready", W'(wr_ready), W'(0));
      check("hold_x4", dut_reg(4), 64'h0);
      @(negedge clk);
    end
    hold = 1'b0;
    #1;
    check("hold_release_ready", W'(wr_ready), W'(1));
    @(negedge clk);
    wr_valid = 1'b0;
    check("hold_x4_after", dut_reg(4), 64'hA5);
    check("hold_x5_not_yet", dut_reg(5), 64'h0);
    check("hold_pend_addr", W'(pend_addr), W'(5));
    @(negedge clk);
    check("hold_x5_after", dut_reg(5), 64'h5A);

    // Zero register
    stage(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    check("zero_pend_addr", W'(pend_addr), W'(31));
    check("zero_pend_valid", W'(pend_valid), W'(1));
    @(negedge clk);
    check("zero_x31", dut_reg(31), 64'h0);
    check("zero_pend_clear", W'(pend_valid), W'(0));

    // Reset mid-operation with a staged write and a stall in place
    stage(5'd7, 64'h77);
    hold = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    for (int r = 0; r < 32; r++) check($sformatf("midrst_x%0d", r), dut_reg(r), 64'h0);
    check("midrst_pend_valid", W'(pend_valid), W'(0));
    check("midrst_pend_addr", W'(pend_addr), W'(0));
    check("midrst_wr_ready", W'(wr_ready), W'(1));
    @(negedge clk);
    reset_n = 1'b1;
    hold    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_x7", dut_reg(7), 64'h0);

    // Random traffic against the reference model
    acc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!(wr_valid && !acc)) begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_addr  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        wr_data  = {$urandom, $urandom};
      end
      hold = ($urandom_range(0, 3) == 0);
      #1;
      acc = wr_valid && wr_ready;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    hold     = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
